fp_multiplier_sp: RTL

//  Sequential IEEE-754 single-precision multiplier; inverse companion of FP_divider_SP.
//  - Reconstructs dividends (quotient x divisor) and serves as a standalone multiply unit.
//  - Mantissa product is built by shift-add; rounding is round-to-nearest-even.
//  - Flag outputs match the divider's: NAN, INF, ZERO, subnormal.

---
 rtl/fp_sp_pkg.sv | 50 +++++
 rtl/fp_sp_unpack.sv | 43 ++++
 rtl/fp_multiplier_sp.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sp_pkg.sv
// Shared single-precision definitions for the FP multiplier and divider.
// Operand classes, FSM states and the unpacked-operand record live here.
package fp_sp_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fsm_state_t;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF,
    SPC_ZERO
  } special_t;

  // exp is the unbiased exponent, two's complement
  typedef struct packed {
    logic      sign;
    logic [9:0] exp;
    logic [23:0] mant;
    op_class_t cls;
  } unpacked_op_t;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

endpackage

// File: rtl/fp_sp_unpack.sv
// Combinational operand unpack: field split, classification and subnormal
// normalisation (FP_MUL_SUBNORMAL_EN; otherwise subnormals read as zero).
module fp_sp_unpack
  import fp_sp_pkg::*;
(
  input  logic [31:0]  op,
  output unpacked_op_t u
);

  logic [7:0]  e;
  logic [22:0] frac;

  assign e    = op[30:23];
  assign frac = op[22:0];

`ifdef FP_MUL_SUBNORMAL_EN
  logic [4:0] lz;
  assign lz = lzc24({1'b0, frac});
`endif

  always_comb begin
    u.sign = op[31];
    u.exp  = '0;
    u.mant = '0;
    u.cls  = CLS_ZERO;
    if (e == 8'hFF) begin
      u.cls = (frac != '0) ? CLS_NAN : CLS_INF;
    end else if (e != 8'h00) begin
      u.cls  = CLS_NORM;
      u.exp  = {2'b00, e} - 10'd127;
      u.mant = {1'b1, frac};
    end else if (frac != '0) begin
`ifdef FP_MUL_SUBNORMAL_EN
      u.cls  = CLS_SUB;
      u.exp  = 10'h382 - {5'b0, lz};
      u.mant = {1'b0, frac} << lz;
`else
      u.cls  = CLS_ZERO;
`endif
    end
  end

endmodule

// File: rtl/fp_multiplier_sp.sv
// Sequential IEEE-754 single-precision multiplier, shift-add mantissa, RNE.
// Subnormal support is enabled by defining FP_MUL_SUBNORMAL_EN.
module fp_multiplier_sp
  import fp_sp_pkg::*;
#(
  parameter int unsigned K         = 1,
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic [31:0] product,
  output logic        NAN,
  output logic        INF,
  output logic        ZERO,
  output logic        subnormal,
  output logic        busy,
  output logic        done
);

  if (!(K == 1 || K == 2 || K == 4)) begin : g_bad_k
    $error("fp_multiplier_sp: K must be 1, 2 or 4");
  end

  localparam logic [4:0] LAST = 5'(24 / K - 1);

  fsm_state_t   state;
  logic [31:0]  op_a, op_b;
  unpacked_op_t ua, ub;
  special_t     spc;
  logic         sign;
  logic [9:0]   exp_sum;
  logic [23:0]  ma;
  logic [47:0]  acc;
  logic [4:0]   cnt;
  logic [23:0]  mant;
  logic         g, st;

  fp_sp_unpack u_unpack_a (.op(op_a), .u(ua));
  fp_sp_unpack u_unpack_b (.op(op_b), .u(ub));

  // acc low half starts as the multiplier; each step consumes its LSB
  function automatic logic [47:0] mult_step(input logic [47:0] a, input logic [23:0] m);
    logic [24:0] hi;
    for (int unsigned i = 0; i < K; i++) begin
      hi = {1'b0, a[47:24]} + (a[0] ? {1'b0, m} : 25'd0);
      a  = {hi, a[23:1]};
    end
    return a;
  endfunction

  logic [31:0]        r_prod;
  logic               r_nan, r_inf, r_zero, r_sub;
  logic signed [10:0] biased, b2;
  logic               up;
  logic [24:0]        m_r;
  logic [23:0]        mfin;

`ifdef FP_MUL_SUBNORMAL_EN
  logic signed [10:0] sh;
  logic [25:0]        ext, shifted, mask;
  logic               lost, sg, ss, sup;
  logic [23:0]        sfrac;
`endif

  always_comb begin
    r_prod = '0;
    r_nan  = 1'b0;
    r_inf  = 1'b0;
    r_zero = 1'b0;
    r_sub  = 1'b0;
    biased = $signed({exp_sum[9], exp_sum}) + 11'sd127;
    up     = g & (st | mant[0]);
    m_r    = {1'b0, mant} + {24'd0, up};
    mfin   = m_r[24] ? m_r[24:1] : m_r[23:0];
    b2     = m_r[24] ? biased + 11'sd1 : biased;
`ifdef FP_MUL_SUBNORMAL_EN
    sh      = 11'sd1 - biased;
    ext     = {mant, g, st};
    shifted = '0;
    mask    = '0;
    lost    = 1'b0;
    sg      = 1'b0;
    ss      = 1'b0;
    sup     = 1'b0;
    sfrac   = '0;
`endif
    if (spc == SPC_NAN) begin
      r_prod = CANON_NAN;
      r_nan  = 1'b1;
    end else if (spc == SPC_INF) begin
      r_prod = POS_INF | {sign, 31'd0};
      r_inf  = 1'b1;
    end else if (spc == SPC_ZERO) begin
      r_prod = {sign, 31'd0};
      r_zero = 1'b1;
    end else if (biased < 11'sd1) begin
`ifdef FP_MUL_SUBNORMAL_EN
      // denormalise with sticky; a carry into bit 23 lands in the exponent field
      if (sh > 11'sd26) begin
        lost = |ext;
      end else begin
        shifted = ext >> sh[4:0];
        mask    = (26'd1 << sh[4:0]) - 26'd1;
        lost    = |(ext & mask);
      end
      sg     = shifted[1];
      ss     = shifted[0] | lost;
      sup    = sg & (ss | shifted[2]);
      sfrac  = shifted[25:2] + {23'd0, sup};
      r_prod = {sign, 7'd0, sfrac};
      r_zero = (sfrac == '0);
      r_sub  = (sfrac != '0) && !sfrac[23];
`else
      r_prod = {sign, 31'd0};
      r_zero = 1'b1;
`endif
    end else if (b2 >= 11'sd255) begin
      r_prod = POS_INF | {sign, 31'd0};
      r_inf  = 1'b1;
    end else begin
      r_prod = {sign, b2[7:0], mfin[22:0]};
    end
  end

`ifdef FP_MUL_SUBNORMAL_EN
  logic sub_q;
  assign subnormal = sub_q;
`else
  assign subnormal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      spc     <= SPC_NONE;
      sign    <= 1'b0;
      exp_sum <= '0;
      ma      <= '0;
      acc     <= '0;
      cnt     <= '0;
      mant    <= '0;
      g       <= 1'b0;
      st      <= 1'b0;
      product <= '0;
      NAN     <= 1'b0;
      INF     <= 1'b0;
      ZERO    <= 1'b0;
`ifdef FP_MUL_SUBNORMAL_EN
      sub_q   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_a  <= OP1;
            op_b  <= OP2;
            busy  <= 1'b1;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          sign    <= ua.sign ^ ub.sign;
          exp_sum <= ua.exp + ub.exp;
          ma      <= ua.mant;
          acc     <= {24'd0, ub.mant};
          cnt     <= '0;
          if (ua.cls == CLS_NAN || ub.cls == CLS_NAN ||
              (ua.cls == CLS_INF && ub.cls == CLS_ZERO) ||
              (ua.cls == CLS_ZERO && ub.cls == CLS_INF))
            spc <= SPC_NAN;
          else if (ua.cls == CLS_INF || ub.cls == CLS_INF)
            spc <= SPC_INF;
          else if (ua.cls == CLS_ZERO || ub.cls == CLS_ZERO)
            spc <= SPC_ZERO;
          else
            spc <= SPC_NONE;
          state <= ST_MULT;
        end
        ST_MULT: begin
          acc <= mult_step(acc, ma);
          cnt <= cnt + 5'd1;
          if (cnt == LAST) state <= ST_NORM;
        end
        ST_NORM: begin
          if (acc[47]) begin
            mant    <= acc[47:24];
            g       <= acc[23];
            st      <= |acc[22:0];
            exp_sum <= exp_sum + 10'd1;
          end else begin
            mant <= acc[46:23];
            g    <= acc[22];
            st   <= |acc[21:0];
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          product <= r_prod;
          NAN     <= r_nan;
          INF     <= r_inf;
          ZERO    <= r_zero;
`ifdef FP_MUL_SUBNORMAL_EN
          sub_q   <= r_sub;
`endif
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef FP_MUL_SUBNORMAL_EN
  logic unused_sub;
  assign unused_sub = r_sub;
`endif

endmodule
